register_window_manager: RTL and testbench

- Controller that sequences the 4-window register file for call/return context switches.
- Owns the current window pointer (CWP) and the resident-window count.
- Spills the oldest window to data memory on call overflow; fills the caller's window back from memory on return underflow.
- Sits between the control unit (call/ret strobes, stall) and the register file's window-select and write ports, with a req/ack port to the data memory arbiter.

---
 rtl/register_window_manager.sv | 148 ++++++++++++++
 tb/tb_register_window_manager.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/register_window_manager.sv
// register_window_manager: CWP/residency control with spill/fill sequencing; WINDOW_STATS_EN adds spill/fill counters
module register_window_manager #(
  parameter int NUM_WINDOWS = 4,
  parameter int REGS_PER_WINDOW = 8,
  parameter int MAX_DEPTH = 16,
  parameter logic [7:0] SPILL_BASE = 8'h80
) (
  input  logic clk,
  input  logic rst,
  input  logic call_req,
  input  logic ret_req,
  output logic busy,
  output logic [$clog2(NUM_WINDOWS)-1:0] cwp,
  output logic [$clog2(NUM_WINDOWS)-1:0] rf_window_select,
  output logic [$clog2(REGS_PER_WINDOW)-1:0] rf_read_addr,
  input  logic [7:0] rf_read_data,
  output logic rf_write_enable,
  output logic [$clog2(REGS_PER_WINDOW)-1:0] rf_write_addr,
  output logic [7:0] rf_write_data,
  output logic mem_req,
  output logic mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic mem_ack,
  output logic stack_overflow,
  output logic underflow_err,
`ifdef WINDOW_STATS_EN
  output logic [15:0] spill_count,
  output logic [15:0] fill_count,
`endif
  output logic proto_err
);
  localparam int WW = $clog2(NUM_WINDOWS);
  localparam int IW = $clog2(REGS_PER_WINDOW);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int RW = $clog2(NUM_WINDOWS + 1);
  localparam logic [RW-1:0] FULL = RW'(NUM_WINDOWS);
  localparam logic [RW-1:0] ONE = RW'(1);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);
  localparam logic [IW-1:0] LAST = IW'(REGS_PER_WINDOW - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SPILL, FILL, FILL_WR, FINISH} state_t;
  state_t state, state_d;

  logic [RW-1:0] resident;
  logic [DW-1:0] depth, slot;
  logic [IW-1:0] idx;
  logic [WW-1:0] tgt;
  logic is_spill;
  logic [7:0] fill_data, addr;
  logic do_call, do_ret, full, call_fast, call_ovf, call_spill, ret_fast, ret_under, ret_fill;
  logic spill_done, fill_done;

  assign do_call = state == IDLE && call_req && !ret_req;
  assign do_ret = state == IDLE && ret_req && !call_req;
  assign full = resident == FULL;
  assign call_fast = do_call && !full;
  assign call_ovf = do_call && full && depth == DMAX;
  assign call_spill = do_call && full && depth != DMAX;
  assign ret_fast = do_ret && resident != ONE;
  assign ret_under = do_ret && resident == ONE && depth == '0;
  assign ret_fill = do_ret && resident == ONE && depth != '0;
  assign spill_done = state == SPILL && mem_ack && idx == LAST;
  assign fill_done = state == FILL_WR && idx == LAST;
  // Fill reads the most recently spilled slot, one below the current depth
  assign slot = is_spill ? depth : depth - 1'b1;
  assign addr = SPILL_BASE + 8'(slot) * 8'(REGS_PER_WINDOW) + 8'(idx);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;

  always_comb begin
    state_d = state;
    busy = state != IDLE;
    rf_window_select = (state == IDLE || state == FINISH) ? cwp : tgt;
    rf_read_addr = state == SPILL ? idx : '0;
    mem_req = state == SPILL || state == FILL;
    mem_we = state == SPILL;
    mem_addr = mem_req ? addr : '0;
    mem_wdata = state == SPILL ? rf_read_data : '0;
    rf_write_enable = state == FILL_WR;
    rf_write_addr = rf_write_enable ? idx : '0;
    rf_write_data = rf_write_enable ? fill_data : '0;
    case (state)
      IDLE:    state_d = (call_spill || ret_fill) ? SETUP : IDLE;
      SETUP:   state_d = is_spill ? SPILL : FILL;
      SPILL:   state_d = spill_done ? FINISH : SPILL;
      FILL:    state_d = mem_ack ? FILL_WR : FILL;
      FILL_WR: state_d = idx == LAST ? FINISH : FILL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cwp <= '0;
      resident <= ONE;
      depth <= '0;
      idx <= '0;
      tgt <= '0;
      is_spill <= 1'b0;
      fill_data <= '0;
      stack_overflow <= 1'b0;
      underflow_err <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      stack_overflow <= call_ovf;
      underflow_err <= ret_under;
      proto_err <= state == IDLE && call_req && ret_req;
      if (call_fast) begin
        cwp <= cwp + 1'b1;
        resident <= resident + 1'b1;
      end
      if (ret_fast) begin
        cwp <= cwp - 1'b1;
        resident <= resident - 1'b1;
      end
      if (call_spill || ret_fill) begin
        tgt <= call_spill ? cwp + 1'b1 : cwp - 1'b1;
        is_spill <= call_spill;
        idx <= '0;
      end
      if (state == SPILL && mem_ack) idx <= idx + 1'b1;
      if (state == FILL && mem_ack) fill_data <= mem_rdata;
      if (state == FILL_WR) idx <= idx + 1'b1;
      if (spill_done) begin
        depth <= depth + 1'b1;
        cwp <= tgt;
      end
      if (fill_done) begin
        depth <= depth - 1'b1;
        cwp <= tgt;
      end
    end

`ifdef WINDOW_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      spill_count <= '0;
      fill_count <= '0;
    end else begin
      if (spill_done && spill_count != 16'hFFFF) spill_count <= spill_count + 1'b1;
      if (fill_done && fill_count != 16'hFFFF) fill_count <= fill_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_register_window_manager.sv
// tb_register_window_manager: directed checks of call/return, spill/fill traffic, errors and reset abort
module tb_register_window_manager;
  logic clk = 1'b0, rst = 1'b1, call_req = 1'b0, ret_req = 1'b0, call2 = 1'b0, ret2 = 1'b0;
  always #5 clk = ~clk;

  logic busy, rf_write_enable, mem_req, mem_we, mem_ack, stack_overflow, underflow_err, proto_err;
  logic [1:0] cwp, rf_window_select;
  logic [2:0] rf_read_addr, rf_write_addr;
  logic [7:0] rf_read_data, rf_write_data, mem_addr, mem_wdata, mem_rdata;
  logic busy2, rf_write_enable2, mem_req2, mem_we2, mem_ack2, stack_overflow2, underflow_err2, proto_err2;
  logic [1:0] cwp2, rf_window_select2;
  logic [2:0] rf_read_addr2, rf_write_addr2;
  logic [7:0] rf_read_data2, rf_write_data2, mem_addr2, mem_wdata2, mem_rdata2;
`ifdef WINDOW_STATS_EN
  logic [15:0] spill_count, fill_count, spill_count2, fill_count2;
`endif

  logic [7:0] rf [4][8];
  logic [7:0] mem [256];
  logic [12:0] rf_log [8];
  int ack_delay = 0, cnt = 0, wr_cnt = 0, rf_wcnt = 0, busy_cyc = 0, req_cyc = 0, req2_cyc = 0;
  int passed = 0, total = 0, b, w, r;

  register_window_manager u_dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req), .busy(busy), .cwp(cwp),
    .rf_window_select(rf_window_select), .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stack_overflow(stack_overflow),
    .underflow_err(underflow_err),
`ifdef WINDOW_STATS_EN
    .spill_count(spill_count), .fill_count(fill_count),
`endif
    .proto_err(proto_err)
  );

  register_window_manager #(.MAX_DEPTH(1)) u_shallow (
    .clk(clk), .rst(rst), .call_req(call2), .ret_req(ret2), .busy(busy2), .cwp(cwp2),
    .rf_window_select(rf_window_select2), .rf_read_addr(rf_read_addr2), .rf_read_data(rf_read_data2),
    .rf_write_enable(rf_write_enable2), .rf_write_addr(rf_write_addr2), .rf_write_data(rf_write_data2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .stack_overflow(stack_overflow2),
    .underflow_err(underflow_err2),
`ifdef WINDOW_STATS_EN
    .spill_count(spill_count2), .fill_count(fill_count2),
`endif
    .proto_err(proto_err2)
  );

  assign rf_read_data = rf[rf_window_select][rf_read_addr];
  assign mem_rdata = mem[mem_addr];
  assign mem_ack = mem_req && cnt == ack_delay;
  assign rf_read_data2 = 8'hA5;
  assign mem_rdata2 = 8'h00;
  assign mem_ack2 = mem_req2;

  // Memory responder with programmable wait, plus activity monitors
  always @(posedge clk) begin
    cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (mem_req) req_cyc <= req_cyc + 1;
    if (mem_req2) req2_cyc <= req2_cyc + 1;
    if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (rf_write_enable) begin
      rf_log[rf_wcnt[2:0]] <= {rf_window_select, rf_write_addr, rf_write_data};
      rf_wcnt <= rf_wcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit c, input bit rr, input bit c2);
    @(negedge clk);
    call_req = c; ret_req = rr; call2 = c2;
    @(negedge clk);
    call_req = 1'b0; ret_req = 1'b0; call2 = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && (busy || busy2); i++) @(negedge clk);
    chk(tag, {busy, busy2}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    for (int wi = 0; wi < 4; wi++)
      for (int i = 0; i < 8; i++) rf[wi][i] = 8'(16 * (wi + 1) + i);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst cwp", cwp, 0);
    chk("rst busy", busy, 0);
    chk("rst sel", rf_window_select, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst rf_we", rf_write_enable, 0);
    chk("rst errs", {stack_overflow, underflow_err, proto_err}, 0);

    b = busy_cyc; r = req_cyc;
    for (int i = 1; i <= 3; i++) begin
      pulse(1, 0, 0);
      chk("call cwp", cwp, i);
      @(negedge clk);
    end
    chk("fast calls busy", busy_cyc - b, 0);
    chk("fast calls mem_req", req_cyc - r, 0);

    b = busy_cyc; w = wr_cnt;
    pulse(1, 0, 0);
    wait_idle("spill timeout");
    chk("spill busy cycles", busy_cyc - b, 10);
    chk("spill cwp", cwp, 0);
    chk("spill writes", wr_cnt - w, 8);
    for (int i = 0; i < 8; i++) chk("spill mem", mem[128 + i], 8'(16 + i));

    b = busy_cyc;
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1, 0);
      chk("ret cwp", cwp, 3 - i);
    end
    chk("fast rets busy", busy_cyc - b, 0);
    pulse(0, 1, 0);
    wait_idle("fill timeout");
    chk("fill busy cycles", busy_cyc - b, 18);
    chk("fill cwp", cwp, 0);
    chk("fill rf writes", rf_wcnt, 8);
    for (int i = 0; i < 8; i++) chk("fill rf log", rf_log[i], {2'b00, 3'(i), 8'(16 + i)});

    do_reset();
    pulse(0, 1, 0);
    chk("underflow pulse", underflow_err, 1);
    chk("underflow cwp", cwp, 0);
    @(negedge clk);
    chk("underflow one cycle", underflow_err, 0);
    pulse(1, 1, 0);
    chk("proto pulse", proto_err, 1);
    chk("proto cwp", cwp, 0);
    chk("proto busy", busy, 0);
    @(negedge clk);
    chk("proto one cycle", proto_err, 0);

    do_reset();
    for (int i = 0; i < 3; i++) pulse(1, 0, 0);
    chk("pre-spill cwp", cwp, 3);
    ack_delay = 3; w = wr_cnt;
    pulse(1, 0, 0);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("slow req seen", mem_req, 1);
    chk("slow addr0", mem_addr, 8'h80);
    chk("slow data0", mem_wdata, 8'h10);
    chk("slow no ack", mem_ack, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold addr", mem_addr, 8'h80);
      chk("hold data", mem_wdata, 8'h10);
      chk("hold req", {mem_req, mem_we, mem_ack}, 3'b110);
    end
    @(negedge clk);
    chk("slow ack", {mem_ack, mem_addr}, {1'b1, 8'h80});
    for (int i = 0; i < 40 && mem_addr !== 8'h84; i++) @(negedge clk);
    chk("idx4 writes", wr_cnt - w, 4);
    chk("idx4 data", mem_wdata, 8'h14);
    #1 rst = 1'b1;
    #1;
    chk("abort mem_req", mem_req, 0);
    chk("abort busy", busy, 0);
    chk("abort cwp", cwp, 0);
    @(negedge clk);
    rst = 1'b0; ack_delay = 0;
    pulse(0, 1, 0);
    chk("abort depth zero", underflow_err, 1);

    do_reset();
    for (int i = 0; i < 3; i++) pulse(0, 0, 1);
    chk("shallow cwp", cwp2, 3);
    r = req2_cyc;
    pulse(0, 0, 1);
    wait_idle("shallow spill timeout");
    chk("shallow spill traffic", req2_cyc - r, 8);
    chk("shallow spill cwp", cwp2, 0);
    r = req2_cyc;
    pulse(0, 0, 1);
    chk("overflow pulse", stack_overflow2, 1);
    chk("overflow cwp", cwp2, 0);
    chk("overflow busy", busy2, 0);
    @(negedge clk);
    chk("overflow one cycle", stack_overflow2, 0);
    repeat (3) @(negedge clk);
    chk("overflow no traffic", req2_cyc - r, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
